sad_vbs_accumulator: RTL and testbench

//  Row-streaming variable-block-size SAD engine for H.264 inter prediction.
//  - Accepts one row of N absolute pixel differences per handshake.
//  - After N rows, presents all 41 H.264 partition SADs of one NxN candidate in one registered beat:
//    4x4, 4x8, 8x4, 8x8, 16x8, 8x16 and 16x16.
//  - Sits between the PE array (abs-diff) and the motion-vector decision logic.
//  - Adds over the combinational 4x4 tree: pipelining, valid/ready flow control, candidate tagging and abort.

---
 rtl/sad_pkg.sv | 25 ++
 rtl/sad_row_acc.sv | 95 +++++++++
 rtl/sad_vbs_accumulator.sv | 135 +++++++++++++
 tb/tb_sad_vbs_accumulator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared partition counts and flat-index helpers for the variable-block-size SAD engine.
package sad_pkg;

    localparam int N_S4X4   = 16;
    localparam int N_S8X4   = 8;
    localparam int N_S4X8   = 8;
    localparam int N_S8X8   = 4;
    localparam int N_S16X8  = 2;
    localparam int N_S8X16  = 2;
    localparam int N_S16X16 = 1;

    // 16 x 16 x (2^pix_w - 1) needs exactly pix_w + 8 bits
    function automatic int sad_w(input int pix_w);
        return pix_w + 8;
    endfunction

    function automatic int idx4(input int r, input int c);
        return r * 4 + c;
    endfunction

    function automatic int idx2(input int r, input int c);
        return r * 2 + c;
    endfunction

endpackage

// File: rtl/sad_row_acc.sv
// Row-to-4x4 reduction: per-row 4-column group sums (S1) folded into band accumulators
// that deposit one row of S4x4 results every fourth row (S2).
module sad_row_acc
    import sad_pkg::*;
#(
    parameter int PIX_WIDTH = 8,
    parameter int N         = 16,
    parameter int SAD_W     = sad_w(PIX_WIDTH),
    localparam int NB       = N / 4,
    localparam int RW       = $clog2(N)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              hold,
    input  logic                              abort,
    input  logic                              beat,
    input  logic [RW-1:0]                     row,
    input  logic [N*PIX_WIDTH-1:0]            ad,
    output logic [N_S4X4-1:0][SAD_W-1:0]      s4x4,
    output logic                              done
);

    localparam int GW = PIX_WIDTH + 2;

    logic [NB-1:0][GW-1:0]        gsum_p0;
    logic [NB-1:0][GW-1:0]        gsum_p1;
    logic [RW-1:0]                row_p1;
    logic                         vld_p1;
    logic [NB-1:0][SAD_W-1:0]     acc_p2;
    logic [N_S4X4-1:0][SAD_W-1:0] s4x4_p2;
    logic                         vld_p2;
    logic [RW-3:0]                band;
    logic                         band_end;

    always_comb begin
        gsum_p0 = '0;
        for (int g = 0; g < NB; g++) begin
            for (int k = 0; k < 4; k++) begin
                gsum_p0[g] = gsum_p0[g] + GW'(ad[(g*4+k)*PIX_WIDTH +: PIX_WIDTH]);
            end
        end
    end

    // S1: group sums tagged with their row index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            row_p1  <= '0;
            gsum_p1 <= '0;
        end else if (abort) begin
            vld_p1 <= 1'b0;
        end else if (!hold) begin
            vld_p1 <= beat;
            if (beat) begin
                row_p1  <= row;
                gsum_p1 <= gsum_p0;
            end
        end
    end

    assign band     = row_p1[RW-1:2];
    assign band_end = &row_p1[1:0];

    // S2: band accumulation; the fourth row of a band lands directly in the S4x4 store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            acc_p2  <= '0;
            s4x4_p2 <= '0;
        end else if (abort) begin
            vld_p2 <= 1'b0;
            acc_p2 <= '0;
        end else if (!hold) begin
            vld_p2 <= vld_p1 && (row_p1 == RW'(N - 1));
            if (vld_p1) begin
                for (int c = 0; c < NB; c++) begin
                    if (band_end) begin
                        acc_p2[c] <= '0;
                        for (int r = 0; r < NB; r++) begin
                            if (int'(band) == r) begin
                                s4x4_p2[idx4(r, c)] <= acc_p2[c] + SAD_W'(gsum_p1[c]);
                            end
                        end
                    end else begin
                        acc_p2[c] <= acc_p2[c] + SAD_W'(gsum_p1[c]);
                    end
                end
            end
        end
    end

    assign s4x4 = s4x4_p2;
    assign done = vld_p2;

endmodule

// File: rtl/sad_vbs_accumulator.sv
// Row-streaming H.264 variable-block-size SAD engine: accumulates N rows of abs diffs and
// presents all 41 partition SADs of one candidate in a single registered, flow-controlled beat.
module sad_vbs_accumulator
    import sad_pkg::*;
#(
    parameter int PIX_WIDTH = 8,
    parameter int N         = 16,
    parameter int CAND_W    = 8,
    localparam int SAD_W    = sad_w(PIX_WIDTH),
    localparam int RW       = $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_abort,
    input  logic [N*PIX_WIDTH-1:0]       in_ad,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CAND_W-1:0]            out_cand,
    output logic [N_S4X4*SAD_W-1:0]      out_s4x4,
    output logic [N_S8X4*SAD_W-1:0]      out_s8x4,
    output logic [N_S4X8*SAD_W-1:0]      out_s4x8,
    output logic [N_S8X8*SAD_W-1:0]      out_s8x8,
    output logic [N_S16X8*SAD_W-1:0]     out_s16x8,
    output logic [N_S8X16*SAD_W-1:0]     out_s8x16,
    output logic [N_S16X16*SAD_W-1:0]    out_s16x16
);

    typedef struct packed {
        logic [N_S4X4-1:0][SAD_W-1:0]   s4x4;
        logic [N_S8X4-1:0][SAD_W-1:0]   s8x4;
        logic [N_S4X8-1:0][SAD_W-1:0]   s4x8;
        logic [N_S8X8-1:0][SAD_W-1:0]   s8x8;
        logic [N_S16X8-1:0][SAD_W-1:0]  s16x8;
        logic [N_S8X16-1:0][SAD_W-1:0]  s8x16;
        logic [N_S16X16-1:0][SAD_W-1:0] s16x16;
    } sad_bundle_t;

    logic                         hold;
    logic                         beat;
    logic [RW-1:0]                row_q;
    logic [N_S4X4-1:0][SAD_W-1:0] s4x4;
    logic                         done;
    sad_bundle_t                  merge_p2;
    sad_bundle_t                  bun_p3;
    logic [CAND_W-1:0]            cand_cnt;

    assign hold     = out_valid & ~out_ready;
    assign in_ready = ~hold;
    assign beat     = in_valid & in_ready & ~in_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
        end else if (in_abort) begin
            row_q <= '0;
        end else if (beat) begin
            row_q <= (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
        end
    end

    sad_row_acc #(
        .PIX_WIDTH (PIX_WIDTH),
        .N         (N),
        .SAD_W     (SAD_W)
    ) u_row_acc (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .abort (in_abort),
        .beat  (beat),
        .row   (row_q),
        .ad    (in_ad),
        .s4x4  (s4x4),
        .done  (done)
    );

    // Unwritten S4x4 cells stay zero for N = 8, so only the 16-wide sizes need explicit ties
    always_comb begin
        merge_p2      = '0;
        merge_p2.s4x4 = s4x4;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                merge_p2.s8x4[idx2(r, c)] = s4x4[idx4(r, 2*c)] + s4x4[idx4(r, 2*c+1)];
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                merge_p2.s4x8[idx4(r, c)] = s4x4[idx4(2*r, c)] + s4x4[idx4(2*r+1, c)];
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                merge_p2.s8x8[idx2(r, c)] = merge_p2.s8x4[idx2(2*r, c)]
                                          + merge_p2.s8x4[idx2(2*r+1, c)];
            end
        end
        if (N == 16) begin
            for (int r = 0; r < 2; r++) begin
                merge_p2.s16x8[r] = merge_p2.s8x8[idx2(r, 0)] + merge_p2.s8x8[idx2(r, 1)];
            end
            for (int c = 0; c < 2; c++) begin
                merge_p2.s8x16[c] = merge_p2.s8x8[idx2(0, c)] + merge_p2.s8x8[idx2(1, c)];
            end
            merge_p2.s16x16[0] = merge_p2.s16x8[0] + merge_p2.s16x8[1];
        end
    end

    // S3: output bundle register and candidate tagging
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_cand  <= '0;
            cand_cnt  <= '0;
            bun_p3    <= '0;
        end else if (!hold) begin
            out_valid <= done;
            if (done) begin
                bun_p3   <= merge_p2;
                out_cand <= cand_cnt;
                cand_cnt <= cand_cnt + CAND_W'(1);
            end
        end
    end

    assign out_s4x4   = bun_p3.s4x4;
    assign out_s8x4   = bun_p3.s8x4;
    assign out_s4x8   = bun_p3.s4x8;
    assign out_s8x8   = bun_p3.s8x8;
    assign out_s16x8  = bun_p3.s16x8;
    assign out_s8x16  = bun_p3.s8x16;
    assign out_s16x16 = bun_p3.s16x16;

endmodule

// File: tb/tb_sad_vbs_accumulator.sv
// Scoreboard bench for sad_vbs_accumulator (N = 16, PIX_WIDTH = 8): directed blocks push
// expected bundles, a monitor pops and compares on every output handshake.
module tb_sad_vbs_accumulator;

    localparam int PW = 8;
    localparam int NN = 16;
    localparam int CW = 8;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_abort;
    logic [NN*PW-1:0]  in_ad;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_cand;
    logic [16*SW-1:0]  out_s4x4;
    logic [8*SW-1:0]   out_s8x4;
    logic [8*SW-1:0]   out_s4x8;
    logic [4*SW-1:0]   out_s8x8;
    logic [2*SW-1:0]   out_s16x8;
    logic [2*SW-1:0]   out_s8x16;
    logic [SW-1:0]     out_s16x16;

    sad_vbs_accumulator #(.PIX_WIDTH(PW), .N(NN), .CAND_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_abort   (in_abort),
        .in_ad      (in_ad),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cand   (out_cand),
        .out_s4x4   (out_s4x4),
        .out_s8x4   (out_s8x4),
        .out_s4x8   (out_s4x8),
        .out_s8x8   (out_s8x8),
        .out_s16x8  (out_s16x8),
        .out_s8x16  (out_s8x16),
        .out_s16x16 (out_s16x16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] s4x4;
        logic [127:0] s8x4;
        logic [127:0] s4x8;
        logic [63:0]  s8x8;
        logic [31:0]  s16x8;
        logic [31:0]  s8x16;
        logic [15:0]  s16x16;
        logic [7:0]   cand;
        int           cyc;
    } exp_t;

    exp_t q[$];

    function automatic exp_t uni(input int v, input int cand, input int c);
        exp_t e;
        for (int i = 0; i < 16; i++) e.s4x4[i*16 +: 16] = 16'(16 * v);
        for (int i = 0; i < 8; i++) begin
            e.s8x4[i*16 +: 16] = 16'(32 * v);
            e.s4x8[i*16 +: 16] = 16'(32 * v);
        end
        for (int i = 0; i < 4; i++) e.s8x8[i*16 +: 16] = 16'(64 * v);
        for (int i = 0; i < 2; i++) begin
            e.s16x8[i*16 +: 16] = 16'(128 * v);
            e.s8x16[i*16 +: 16] = 16'(128 * v);
        end
        e.s16x16 = 16'(256 * v);
        e.cand   = 8'(cand);
        e.cyc    = c;
        return e;
    endfunction

    function automatic logic [127:0] row_of(input int v);
        logic [127:0] r;
        for (int x = 0; x < 16; x++) r[x*8 +: 8] = 8'(v);
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got cand %0d expected no bundle", out_cand);
            end else begin
                e = q.pop_front();
                chk("s4x4", out_s4x4, e.s4x4);
                chk("s8x4", out_s8x4, e.s8x4);
                chk("s4x8", out_s4x8, e.s4x8);
                chk("s8x8", out_s8x8, e.s8x8);
                chk("s16x8", out_s16x8, e.s16x8);
                chk("s8x16", out_s8x16, e.s8x16);
                chk("s16x16", out_s16x16, e.s16x16);
                chk("cand", out_cand, e.cand);
                if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic beat(input logic [127:0] ad, input logic abort, output int c);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ad    = ad;
        in_abort = abort;
        #1;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready 0 after %0d cycles, expected 1", guard);
        end
        c = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_abort = 1'b0;
    endtask

    task automatic send_uni(input int v, input int rows, output int clast);
        for (int i = 0; i < rows; i++) beat(row_of(v), 1'b0, clast);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(negedge clk);
            #3;
            g++;
        end
        checks++;
        if (q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_%s: %0d bundles pending, expected 0", name, q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cl;
        int   cl2;
        int   g;
        exp_t e;
        logic [127:0] r;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_abort  = 1'b0;
        in_ad     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_cand", out_cand, 8'd0);
        chk("reset_s16x16", out_s16x16, 16'd0);
        chk("reset_s4x4", out_s4x4, 256'd0);

        // all ones, latency checked against the last accepted row
        send_uni(1, 16, cl);
        q.push_back(uni(1, 0, cl + 3));
        wait_drain("ones");

        // full-scale block followed back-to-back by another block
        q.push_back(uni(255, 1, -1));
        q.push_back(uni(3, 2, -1));
        send_uni(255, 16, cl);
        send_uni(3, 16, cl);
        wait_drain("b2b");

        // single diff of 7 at row 5, column 9
        e = uni(0, 3, -1);
        e.s4x4[6*16 +: 16]  = 16'd7;
        e.s8x4[3*16 +: 16]  = 16'd7;
        e.s4x8[2*16 +: 16]  = 16'd7;
        e.s8x8[1*16 +: 16]  = 16'd7;
        e.s16x8[0 +: 16]    = 16'd7;
        e.s8x16[16 +: 16]   = 16'd7;
        e.s16x16            = 16'd7;
        q.push_back(e);
        for (int i = 0; i < 16; i++) begin
            r = '0;
            if (i == 5) r[9*8 +: 8] = 8'd7;
            beat(r, 1'b0, cl);
        end
        wait_drain("single");

        // consumer stall with a second block streaming behind
        @(negedge clk);
        out_ready = 1'b0;
        q.push_back(uni(4, 4, -1));
        q.push_back(uni(5, 5, -1));
        send_uni(4, 16, cl);
        fork
            send_uni(5, 16, cl2);
            begin
                g = 0;
                while (!out_valid && g < 20) begin
                    @(negedge clk);
                    #1;
                    g++;
                end
                chk("stall_out_valid_rise", out_valid, 1'b1);
                chk("stall_in_ready_low", in_ready, 1'b0);
                repeat (8) @(negedge clk);
                #1;
                chk("stall_held_valid", out_valid, 1'b1);
                chk("stall_held_s16x16", out_s16x16, 16'd1024);
                chk("stall_held_cand", out_cand, 8'd4);
                chk("stall_in_ready_still_low", in_ready, 1'b0);
                out_ready = 1'b1;
            end
        join
        wait_drain("stall");

        // abort after seven rows; the abort beat also carries data that must be dropped
        q.push_back(uni(2, 6, -1));
        send_uni(9, 7, cl);
        beat(row_of(9), 1'b1, cl);
        send_uni(2, 16, cl);
        wait_drain("abort");

        // reset in the middle of a block
        send_uni(6, 11, cl);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_s16x16", out_s16x16, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("postrst_out_valid", out_valid, 1'b0);
        chk("postrst_out_cand", out_cand, 8'd0);
        chk("postrst_s8x8", out_s8x8, 64'd0);
        chk("postrst_in_ready", in_ready, 1'b1);
        q.push_back(uni(1, 0, -1));
        send_uni(1, 16, cl);
        wait_drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
